// File: rtl/jtag_1149_d10_mstr_pkg.sv
// Shared definitions for the IEEE 1149.10 master transmit scheduler:
// state encodings, packet type constants and parameter defaults.
package jtag_1149_d10_mstr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LAUNCH   = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_GAP      = 3'd4,
        ST_LPBK     = 3'd5,
        ST_ERROR    = 3'd6
    } sched_state_e;

    // Upper bits of every normal PEDDA packet type; the low bits carry the instruction code.
    localparam logic [4:0] PKT_PREFIX    = 5'b10110;
    // Chosen outside the PKT_PREFIX range so loopback packets are never mistaken for instructions.
    localparam logic [7:0] LPBK_PKT_TYPE = 8'h3C;

    localparam int MAX_RETRY_DEF = 4;
    localparam int IDLE_GAP_DEF  = 4;

endpackage

// File: rtl/jtag_1149_d10_mstr_gap_counter.sv
// Loadable down-counter with terminal-count flag; times the inter-packet gap.
module jtag_1149_d10_mstr_gap_counter #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 tc_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count only matters while the owner is actively counting.
    assign tc_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/jtag_1149_d10_mstr_tx_pkt_scheduler.sv
// Master-side PEDDA packet scheduler: one outstanding packet at a time, with
// retry, flow-control stall, loopback arbitration and a sticky error state.
module jtag_1149_d10_mstr_tx_pkt_scheduler
    import jtag_1149_d10_mstr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_RETRY  = MAX_RETRY_DEF,
    parameter int IDLE_GAP   = IDLE_GAP_DEF,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_vld,
    input  logic [DATA_WIDTH-6:0] instr_type,
    output logic                  instr_rdy,
    input  logic                  lpbk_req,
    input  logic                  tx_pkt_done,
    input  logic                  rd_nxt_instr,
    input  logic                  instr_retry,
    input  logic                  scan_rsp_time_out,
    input  logic                  unrecoverable_error,
    input  logic                  suspend_xmission,
    input  logic                  exit_lpbk,
    input  logic                  err_clr,
    output logic                  send_pkt,
    output logic [DATA_WIDTH-1:0] send_pkt_type,
    output logic                  sched_busy,
    output logic                  sched_error,
    output logic [CNT_WIDTH-1:0]  retry_cnt
);

    localparam int                   TYPE_W     = DATA_WIDTH - 5;
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD   = CNT_WIDTH'(IDLE_GAP - 1);
    localparam logic [CNT_WIDTH-1:0] RETRY_LAST = CNT_WIDTH'(MAX_RETRY - 1);

    sched_state_e          state_q,         state_d;
    logic [TYPE_W-1:0]     cur_type_q,      cur_type_d;
    logic                  instr_rdy_q,     instr_rdy_d;
    logic                  send_pkt_q,      send_pkt_d;
    logic [DATA_WIDTH-1:0] send_pkt_type_q, send_pkt_type_d;
    logic                  sched_busy_q,    sched_busy_d;
    logic                  sched_error_q,   sched_error_d;
    logic [CNT_WIDTH-1:0]  retry_cnt_q,     retry_cnt_d;
    logic                  relaunch_q,      relaunch_d;
    logic                  lpbk_sent_q,     lpbk_sent_d;

    logic gap_load;
    logic gap_dec;
    logic gap_tc;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign gap_dec = (state_q == ST_GAP);

    jtag_1149_d10_mstr_gap_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_gap_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .tc_o       (gap_tc)
    );

    always_comb begin
        state_d         = state_q;
        cur_type_d      = cur_type_q;
        instr_rdy_d     = 1'b0;
        send_pkt_d      = 1'b0;
        send_pkt_type_d = send_pkt_type_q;
        retry_cnt_d     = retry_cnt_q;
        relaunch_d      = relaunch_q;
        lpbk_sent_d     = lpbk_sent_q;
        gap_load        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (lpbk_req) begin
                    state_d         = ST_LPBK;
                    send_pkt_type_d = DATA_WIDTH'(LPBK_PKT_TYPE);
                    lpbk_sent_d     = 1'b0;
                end else if (instr_vld) begin
                    state_d     = ST_LAUNCH;
                    cur_type_d  = instr_type;
                    instr_rdy_d = 1'b1;
                    retry_cnt_d = '0;
                end
            end
            ST_LAUNCH: begin
                if (!suspend_xmission) begin
                    state_d         = ST_WAIT_TX;
                    send_pkt_d      = 1'b1;
                    send_pkt_type_d = {PKT_PREFIX, cur_type_q};
                end
            end
            ST_WAIT_TX: begin
                if (tx_pkt_done) begin
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // Success outranks a simultaneous retry; a fatal error outranks both.
                if (unrecoverable_error) begin
                    state_d = ST_ERROR;
                end else if (rd_nxt_instr) begin
                    state_d    = ST_GAP;
                    relaunch_d = 1'b0;
                    gap_load   = 1'b1;
                end else if (instr_retry || scan_rsp_time_out) begin
                    if (retry_cnt_q == RETRY_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d     = ST_GAP;
                        retry_cnt_d = sat_inc(retry_cnt_q);
                        relaunch_d  = 1'b1;
                        gap_load    = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    state_d = relaunch_q ? ST_LAUNCH : ST_IDLE;
                end
            end
            ST_LPBK: begin
                if (!lpbk_sent_q && !suspend_xmission) begin
                    send_pkt_d  = 1'b1;
                    lpbk_sent_d = 1'b1;
                end
                if (exit_lpbk) begin
                    state_d    = ST_GAP;
                    relaunch_d = 1'b0;
                    gap_load   = 1'b1;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_d     = ST_IDLE;
                    retry_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the next state so they line up with state_q.
        sched_busy_d  = (state_d != ST_IDLE);
        sched_error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cur_type_q      <= '0;
            instr_rdy_q     <= 1'b0;
            send_pkt_q      <= 1'b0;
            send_pkt_type_q <= '0;
            sched_busy_q    <= 1'b0;
            sched_error_q   <= 1'b0;
            retry_cnt_q     <= '0;
            relaunch_q      <= 1'b0;
            lpbk_sent_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_type_q      <= cur_type_d;
            instr_rdy_q     <= instr_rdy_d;
            send_pkt_q      <= send_pkt_d;
            send_pkt_type_q <= send_pkt_type_d;
            sched_busy_q    <= sched_busy_d;
            sched_error_q   <= sched_error_d;
            retry_cnt_q     <= retry_cnt_d;
            relaunch_q      <= relaunch_d;
            lpbk_sent_q     <= lpbk_sent_d;
        end
    end

    assign instr_rdy     = instr_rdy_q;
    assign send_pkt      = send_pkt_q;
    assign send_pkt_type = send_pkt_type_q;
    assign sched_busy    = sched_busy_q;
    assign sched_error   = sched_error_q;
    assign retry_cnt     = retry_cnt_q;

endmodule

// File: tb/tb_jtag_1149_d10_mstr_tx_pkt_scheduler.sv
// Bench for the master packet scheduler: randomized transactions whose launch
// and pop edges are predicted from the timing rules and compared with logs.
module tb_jtag_1149_d10_mstr_tx_pkt_scheduler;

    localparam int         DATA_WIDTH = 8;
    localparam int         MAX_RETRY  = 4;
    localparam int         IDLE_GAP   = 4;
    localparam int         CNT_WIDTH  = 5;
    localparam logic [4:0] PREFIX     = 5'b10110;
    localparam logic [7:0] LPBK_TYPE  = 8'h3C;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  instr_vld = 1'b0;
    logic [2:0]            instr_type = '0;
    logic                  instr_rdy;
    logic                  lpbk_req = 1'b0;
    logic                  tx_pkt_done = 1'b0;
    logic                  rd_nxt_instr = 1'b0;
    logic                  instr_retry = 1'b0;
    logic                  scan_rsp_time_out = 1'b0;
    logic                  unrecoverable_error = 1'b0;
    logic                  suspend_xmission = 1'b0;
    logic                  exit_lpbk = 1'b0;
    logic                  err_clr = 1'b0;
    logic                  send_pkt;
    logic [DATA_WIDTH-1:0] send_pkt_type;
    logic                  sched_busy;
    logic                  sched_error;
    logic [CNT_WIDTH-1:0]  retry_cnt;

    int e      = 0;
    int checks = 0;
    int errors = 0;

    int         got_send_e[$];
    logic [7:0] got_send_t[$];
    int         got_rdy_e[$];
    int         exp_send_e[$];
    logic [7:0] exp_send_t[$];
    int         exp_rdy_e[$];

    jtag_1149_d10_mstr_tx_pkt_scheduler #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_RETRY  (MAX_RETRY),
        .IDLE_GAP   (IDLE_GAP),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_vld           (instr_vld),
        .instr_type          (instr_type),
        .instr_rdy           (instr_rdy),
        .lpbk_req            (lpbk_req),
        .tx_pkt_done         (tx_pkt_done),
        .rd_nxt_instr        (rd_nxt_instr),
        .instr_retry         (instr_retry),
        .scan_rsp_time_out   (scan_rsp_time_out),
        .unrecoverable_error (unrecoverable_error),
        .suspend_xmission    (suspend_xmission),
        .exit_lpbk           (exit_lpbk),
        .err_clr             (err_clr),
        .send_pkt            (send_pkt),
        .send_pkt_type       (send_pkt_type),
        .sched_busy          (sched_busy),
        .sched_error         (sched_error),
        .retry_cnt           (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // One clock edge; outputs are sampled 1ns later and pulse inputs are dropped.
    task automatic step();
        @(posedge clk);
        #1;
        e++;
        if (send_pkt === 1'b1) begin
            got_send_e.push_back(e);
            got_send_t.push_back(send_pkt_type);
        end
        if (instr_rdy === 1'b1) got_rdy_e.push_back(e);
        tx_pkt_done         = 1'b0;
        rd_nxt_instr        = 1'b0;
        instr_retry         = 1'b0;
        scan_rsp_time_out   = 1'b0;
        unrecoverable_error = 1'b0;
        exit_lpbk           = 1'b0;
        err_clr             = 1'b0;
    endtask

    task automatic advance_to(input int target);
        while (e < target) step();
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_send_count"}, 32'(got_send_e.size()), 32'(exp_send_e.size()));
        for (int i = 0; i < exp_send_e.size() && i < got_send_e.size(); i++) begin
            chk({tag, "_send_edge"}, 32'(got_send_e[i]), 32'(exp_send_e[i]));
            chk({tag, "_send_type"}, 32'(got_send_t[i]), 32'(exp_send_t[i]));
        end
        chk({tag, "_pop_count"}, 32'(got_rdy_e.size()), 32'(exp_rdy_e.size()));
        for (int i = 0; i < exp_rdy_e.size() && i < got_rdy_e.size(); i++)
            chk({tag, "_pop_edge"}, 32'(got_rdy_e[i]), 32'(exp_rdy_e[i]));
        got_send_e.delete(); got_send_t.delete(); got_rdy_e.delete();
        exp_send_e.delete(); exp_send_t.delete(); exp_rdy_e.delete();
    endtask

    // Expect a launch at edge l, finish serialising, then answer with 'kind':
    // 0 success, 1 retry, 2 timeout, 3 no answer, 4 unrecoverable.
    task automatic serve(input int l, input logic [7:0] ty, input int kind, output int m);
        int d;
        exp_send_e.push_back(l);
        exp_send_t.push_back(ty);
        advance_to(l);
        d = int'($urandom_range(1, 3));
        if (d > 1) rd_nxt_instr = 1'b1;
        advance_to(l + d - 1);
        tx_pkt_done = 1'b1;
        step();
        m = e;
        if (kind == 3) return;
        d = int'($urandom_range(1, 3));
        advance_to(e + d - 1);
        case (kind)
            0: begin rd_nxt_instr = 1'b1; instr_retry = 1'($urandom_range(0, 1)); end
            1: instr_retry = 1'b1;
            2: scan_rsp_time_out = 1'b1;
            default: begin unrecoverable_error = 1'b1; rd_nxt_instr = 1'($urandom_range(0, 1)); end
        endcase
        step();
        m = e;
    endtask

    // ending: 0 success after nfail retries, 1 retry exhaustion, 2 unrecoverable after nfail retries.
    task automatic run_instr(input logic [2:0] t, input int nfail, input int susp, input int ending);
        int n, l, m, nl, kind;
        logic [7:0] ty;
        ty = {PREFIX, t};
        instr_vld  = 1'b1;
        instr_type = t;
        step();
        n = e;
        instr_vld = 1'b0;
        exp_rdy_e.push_back(n);
        chk("busy_after_pop", 32'(sched_busy), 32'(1));
        chk("retry_clr_on_pop", 32'(retry_cnt), 32'(0));
        if (susp > 0) begin
            suspend_xmission = 1'b1;
            repeat (susp) step();
            suspend_xmission = 1'b0;
        end
        l  = n + 1 + susp;
        m  = l;
        nl = (ending == 1) ? MAX_RETRY : nfail + 1;
        for (int k = 0; k < nl; k++) begin
            if (k < nl - 1) kind = (ending == 1) ? 2 : int'($urandom_range(1, 2));
            else            kind = (ending == 0) ? 0 : (ending == 1) ? 2 : 4;
            serve(l, ty, kind, m);
            if (k < nl - 1) begin
                chk("retry_cnt_step", 32'(retry_cnt), 32'(k + 1));
                rd_nxt_instr = 1'b1;
                l = m + IDLE_GAP + 1;
            end
        end
        if (ending == 0) begin
            chk("retry_cnt_final", 32'(retry_cnt), 32'(nfail));
            chk("no_error", 32'(sched_error), 32'(0));
            advance_to(m + IDLE_GAP - 1);
            chk("busy_in_gap", 32'(sched_busy), 32'(1));
            step();
            chk("idle_after_gap", 32'(sched_busy), 32'(0));
        end else begin
            chk("error_set", 32'(sched_error), 32'(1));
            chk("busy_in_error", 32'(sched_busy), 32'(1));
            chk("retry_cnt_error", 32'(retry_cnt), 32'((ending == 1) ? MAX_RETRY - 1 : nfail));
        end
    endtask

    task automatic clear_error(input logic [2:0] t);
        instr_vld  = 1'b1;
        instr_type = t;
        repeat (8) step();
        chk("error_sticky", 32'(sched_error), 32'(1));
        chk("no_strobe_in_error", 32'(send_pkt), 32'(0));
        instr_vld = 1'b0;
        err_clr   = 1'b1;
        step();
        chk("error_cleared", 32'(sched_error), 32'(0));
        chk("idle_after_clr", 32'(sched_busy), 32'(0));
        chk("retry_clr_after_clr", 32'(retry_cnt), 32'(0));
        repeat (3) step();
        chk("still_idle", 32'(sched_busy), 32'(0));
    endtask

    task automatic run_lpbk(input logic [2:0] t, input int nfail);
        int p, s, x;
        s = int'($urandom_range(0, 4));
        lpbk_req   = 1'b1;
        instr_vld  = 1'b1;
        instr_type = t;
        step();
        p = e;
        lpbk_req = 1'b0;
        chk("lpbk_busy", 32'(sched_busy), 32'(1));
        chk("lpbk_no_pop", 32'(instr_rdy), 32'(0));
        if (s > 0) begin
            suspend_xmission = 1'b1;
            repeat (s) step();
            suspend_xmission = 1'b0;
        end
        exp_send_e.push_back(p + 1 + s);
        exp_send_t.push_back(LPBK_TYPE);
        advance_to(p + 1 + s + int'($urandom_range(0, 2)));
        exit_lpbk = 1'b1;
        step();
        x = e;
        advance_to(x + IDLE_GAP);
        chk("lpbk_gap_to_idle", 32'(sched_busy), 32'(0));
        run_instr(t, nfail, 0, 0);
    endtask

    initial begin
        int m, m2, n;
        logic [2:0] t;

        repeat (3) step();
        chk("rst_instr_rdy", 32'(instr_rdy), 32'(0));
        chk("rst_send_pkt", 32'(send_pkt), 32'(0));
        chk("rst_send_type", 32'(send_pkt_type), 32'(0));
        chk("rst_busy", 32'(sched_busy), 32'(0));
        chk("rst_error", 32'(sched_error), 32'(0));
        chk("rst_retry_cnt", 32'(retry_cnt), 32'(0));
        rst = 1'b0;
        step();
        check_logs("reset");

        run_instr(3'b101, 0, 0, 0);
        check_logs("normal");

        run_instr(3'($urandom_range(0, 7)), 3, 0, 0);
        check_logs("retry3");

        run_instr(3'($urandom_range(0, 7)), 0, 0, 1);
        clear_error(3'($urandom_range(0, 7)));
        check_logs("exhaust");

        run_instr(3'($urandom_range(0, 7)), 1, 0, 2);
        clear_error(3'($urandom_range(0, 7)));
        check_logs("unrecoverable");

        run_instr(3'($urandom_range(0, 7)), 0, 20, 0);
        check_logs("suspend20");

        run_lpbk(3'($urandom_range(0, 7)), 1);
        check_logs("lpbk_arb");

        t = 3'($urandom_range(0, 7));
        instr_vld  = 1'b1;
        instr_type = t;
        step();
        n = e;
        instr_vld = 1'b0;
        exp_rdy_e.push_back(n);
        serve(n + 1, {PREFIX, t}, 1, m);
        serve(m + IDLE_GAP + 1, {PREFIX, t}, 3, m2);
        step();
        chk("pre_rst_busy", 32'(sched_busy), 32'(1));
        chk("pre_rst_retry", 32'(retry_cnt), 32'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_instr_rdy", 32'(instr_rdy), 32'(0));
        chk("midrst_send_pkt", 32'(send_pkt), 32'(0));
        chk("midrst_send_type", 32'(send_pkt_type), 32'(0));
        chk("midrst_busy", 32'(sched_busy), 32'(0));
        chk("midrst_error", 32'(sched_error), 32'(0));
        chk("midrst_retry_cnt", 32'(retry_cnt), 32'(0));
        rd_nxt_instr = 1'b1;
        repeat (6) step();
        chk("late_rsp_ignored", 32'(sched_busy), 32'(0));
        check_logs("midrst");

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) == 0)
                run_lpbk(3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
            else
                run_instr(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 4)), 0);
            check_logs("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
